// File: rtl/mil_tx_fifo_dual.sv
// MIL-STD-1553 Manchester-II word transmitter with an input FIFO, an internal
// half-bit timebase and dual-redundant (A/B) bus outputs. Words are queued
// with a type, a bus select and a payload. They are sent MSB first and framed
// by a 3+3 half-bit sync and an odd-parity bit. A programmable idle gap
// follows each message.
module mil_tx_fifo_dual #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 25,
    parameter int GAP_HB     = 8
) (
    input  logic                          clk,
    input  logic                          nRst,
    input  logic                          inValid,
    output logic                          inReady,
    input  logic [1:0]                    inType,
    input  logic                          inBus,
    input  logic [DATA_WIDTH-1:0]         inData,
    input  logic                          grant,
    input  logic                          abort,
    output logic                          busy,
    output logic                          request,
    output logic                          txA,
    output logic                          nTxA,
    output logic                          txB,
    output logic                          nTxB,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int HBW = $clog2(CLK_DIV);
    localparam int HCW = $clog2(GAP_HB + 3);
    localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int EW  = DATA_WIDTH + 3;

    localparam logic [HBW-1:0] HB_LAST   = HBW'(CLK_DIV - 1);
    localparam logic [HCW-1:0] GAP_LAST  = HCW'(GAP_HB - 1);
    localparam logic [HCW-1:0] SYNC_LAST = HCW'(2);
    localparam logic [BW-1:0]  BIT_TOP   = BW'(DATA_WIDTH - 1);
    localparam logic [LW-1:0]  FULL_LVL  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SYNC1,
        SYNC2,
        DATA,
        PARITY,
        GAP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   count_reg;
    logic [LW-1:0]   count_next;
    logic            ready_reg;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [EW-1:0]   head;
    logic [1:0]      head_type;
    logic            head_bus;
    logic [DATA_WIDTH-1:0] head_data;

    // ------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------
    state_t                state_reg, state_next;
    logic [HBW-1:0]        hb_reg, hb_next;
    logic [HCW-1:0]        hc_reg, hc_next;
    logic [BW-1:0]         bit_reg, bit_next;
    logic                  par_reg, par_next;
    logic [1:0]            type_reg, type_next;
    logic                  bus_reg, bus_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  in_msg_reg, in_msg_next;
    logic                  hb_tick;
    logic                  line_next;
    logic                  active_next;

    // An abort flushes the queue, so a push in the same cycle is dropped.
    assign push       = inValid && ready_reg && !abort;
    assign fifo_empty = (count_reg == '0);
    assign head       = mem[rd_ptr_reg];
    assign head_type  = head[EW-1 -: 2];
    assign head_bus   = head[DATA_WIDTH];
    assign head_data  = head[DATA_WIDTH-1:0];

    assign hb_tick    = (hb_reg == HB_LAST);

    assign inReady    = ready_reg;
    assign fifoLevel  = count_reg;
    assign busy       = (state_reg != IDLE);
    assign request    = busy || !fifo_empty;

    // Word storage: written on an accepted push, read asynchronously at the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {inType, inBus, inData};
        end
    end

    // Occupancy update: abort empties the queue, push+pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        if (abort) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    // FIFO pointers, level and the registered not-full flag.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            ready_reg <= (count_next != FULL_LVL);
            if (abort) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
        end
    end

    // Next-state logic: sequencing of sync, data, parity and gap half-bits.
    always_comb begin
        state_next  = state_reg;
        hc_next     = hc_reg;
        bit_next    = bit_reg;
        par_next    = par_reg;
        type_next   = type_reg;
        bus_next    = bus_reg;
        data_next   = data_reg;
        in_msg_next = in_msg_reg;
        pop         = 1'b0;

        // The timebase only runs once a word is actually on the line, so the
        // first half-bit after LOAD is a full CLK_DIV cycles long.
        if (state_reg == IDLE || state_reg == LOAD || hb_tick) begin
            hb_next = '0;
        end else begin
            hb_next = hb_reg + 1'b1;
        end

        if (abort) begin
            state_next  = IDLE;
            hb_next     = '0;
            hc_next     = '0;
            in_msg_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty && grant) begin
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    pop       = 1'b1;
                    type_next = head_type;
                    bus_next  = head_bus;
                    data_next = head_data;
                    par_next  = 1'b1;
                    bit_next  = BIT_TOP;
                    hc_next   = '0;
                    if (head_type == 2'd0) begin
                        // Discarded word: close an ongoing message with a gap,
                        // otherwise there is nothing to close.
                        if (in_msg_reg) begin
                            state_next = GAP;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = SYNC1;
                    end
                end
                SYNC1: begin
                    if (hb_tick) begin
                        if (hc_reg == SYNC_LAST) begin
                            hc_next    = '0;
                            state_next = SYNC2;
                        end else begin
                            hc_next = hc_reg + 1'b1;
                        end
                    end
                end
                SYNC2: begin
                    if (hb_tick) begin
                        if (hc_reg == SYNC_LAST) begin
                            hc_next    = '0;
                            state_next = DATA;
                        end else begin
                            hc_next = hc_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (hb_tick) begin
                        if (hc_reg == '0) begin
                            hc_next = HCW'(1);
                        end else begin
                            hc_next  = '0;
                            par_next = par_reg ^ data_reg[bit_reg];
                            if (bit_reg == '0) begin
                                state_next = PARITY;
                            end else begin
                                bit_next = bit_reg - 1'b1;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (hb_tick) begin
                        if (hc_reg == '0) begin
                            hc_next = HCW'(1);
                        end else begin
                            hc_next = '0;
                            // Continue the message only on the same bus; a
                            // bus change goes back through arbitration.
                            if (!fifo_empty && head_bus == bus_reg) begin
                                state_next  = LOAD;
                                in_msg_next = 1'b1;
                            end else begin
                                state_next = GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (hb_tick) begin
                        if (hc_reg == GAP_LAST) begin
                            hc_next     = '0;
                            in_msg_next = 1'b0;
                            state_next  = IDLE;
                        end else begin
                            hc_next = hc_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Line level for the upcoming cycle, derived from the next-state values
    // so the registered outputs change on the same edge as the state.
    always_comb begin
        line_next   = 1'b0;
        active_next = 1'b0;
        case (state_next)
            SYNC1: begin
                active_next = 1'b1;
                line_next   = (type_next != 2'd1);
            end
            SYNC2: begin
                active_next = 1'b1;
                line_next   = (type_next == 2'd1);
            end
            DATA: begin
                active_next = 1'b1;
                line_next   = data_next[bit_next] ^ hc_next[0];
            end
            PARITY: begin
                active_next = 1'b1;
                line_next   = par_next ^ hc_next[0];
            end
            default: begin
                active_next = 1'b0;
                line_next   = 1'b0;
            end
        endcase
    end

    // Transmitter FSM registers and the registered bus-pair outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg  <= IDLE;
            hb_reg     <= '0;
            hc_reg     <= '0;
            bit_reg    <= '0;
            par_reg    <= 1'b0;
            type_reg   <= 2'd0;
            bus_reg    <= 1'b0;
            data_reg   <= '0;
            in_msg_reg <= 1'b0;
            txA        <= 1'b0;
            nTxA       <= 1'b0;
            txB        <= 1'b0;
            nTxB       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hb_reg     <= hb_next;
            hc_reg     <= hc_next;
            bit_reg    <= bit_next;
            par_reg    <= par_next;
            type_reg   <= type_next;
            bus_reg    <= bus_next;
            data_reg   <= data_next;
            in_msg_reg <= in_msg_next;
            txA        <= active_next && !bus_next && line_next;
            nTxA       <= active_next && !bus_next && !line_next;
            txB        <= active_next && bus_next && line_next;
            nTxB       <= active_next && bus_next && !line_next;
        end
    end

endmodule

// File: tb/tb_mil_tx_fifo_dual.sv
// Directed testbench for mil_tx_fifo_dual with DATA_WIDTH=16, CLK_DIV=4,
// GAP_HB=8. Line waveforms are captured per clock and compared against a
// half-bit model of the Manchester framing.
module tb_mil_tx_fifo_dual;

    localparam int DW   = 16;
    localparam int DEP  = 8;
    localparam int CDIV = 4;
    localparam int GAPH = 8;
    localparam int HBN  = 2 * DW + 8;
    localparam int NS   = HBN * CDIV;
    localparam int PAR0 = (6 + 2 * DW) * CDIV;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [1:0]    inType = 2'd0;
    logic          inBus = 1'b0;
    logic [DW-1:0] inData = '0;
    logic          grant = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          request;
    logic          txA, nTxA, txB, nTxB;
    logic [3:0]    fifoLevel;

    int checks = 0;
    int errors = 0;

    logic cap_tx  [NS];
    logic cap_ntx [NS];
    logic cap_oth [NS];

    mil_tx_fifo_dual #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEP),
        .CLK_DIV(CDIV),
        .GAP_HB(GAPH)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .inValid(inValid),
        .inReady(inReady),
        .inType(inType),
        .inBus(inBus),
        .inData(inData),
        .grant(grant),
        .abort(abort),
        .busy(busy),
        .request(request),
        .txA(txA),
        .nTxA(nTxA),
        .txB(txB),
        .nTxB(nTxB),
        .fifoLevel(fifoLevel)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Expected line level of half-bit hbi of a word.
    function automatic logic exp_level(input logic [1:0] t, input logic [DW-1:0] d, input int hbi);
        logic s;
        logic p;
        int   k;
        s = (t != 2'd1);
        p = ~(^d);
        k = (hbi - 6) / 2;
        if (hbi < 3) return s;
        if (hbi < 6) return !s;
        if (hbi < 6 + 2 * DW) return ((hbi - 6) % 2 == 0) ? d[DW-1-k] : !d[DW-1-k];
        return (hbi == 6 + 2 * DW) ? p : !p;
    endfunction

    // Number of captured cycles that differ from the modelled waveform.
    function automatic int word_errors(input logic [1:0] t, input logic [DW-1:0] d);
        int n;
        logic lvl;
        n = 0;
        for (int i = 0; i < NS; i++) begin
            lvl = exp_level(t, d, i / CDIV);
            if (cap_tx[i] !== lvl || cap_ntx[i] !== !lvl || cap_oth[i] !== 1'b0) n++;
        end
        return n;
    endfunction

    task automatic push_word(input logic [1:0] t, input logic b, input logic [DW-1:0] d);
        inValid = 1'b1;
        inType  = t;
        inBus   = b;
        inData  = d;
        @(negedge clk);
        inValid = 1'b0;
    endtask

    // Waits for activity on the chosen bus, then records one word's worth of cycles.
    task automatic capture_word(input logic bus, input int max_wait, output int waited, output logic found);
        waited = 0;
        found  = 1'b0;
        while (!found && waited <= max_wait) begin
            @(negedge clk);
            if ((bus ? (txB | nTxB) : (txA | nTxA)) === 1'b1) found = 1'b1;
            else waited++;
        end
        if (found) begin
            for (int i = 0; i < NS; i++) begin
                if (i > 0) @(negedge clk);
                cap_tx[i]  = bus ? txB : txA;
                cap_ntx[i] = bus ? nTxB : nTxA;
                cap_oth[i] = bus ? (txA | nTxA) : (txB | nTxB);
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int n);
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({txA, nTxA, txB, nTxB} !== 4'b0000) begin
            errors++; $display("FAIL reset_lines: got %b, expected 0000", {txA, nTxA, txB, nTxB});
        end
        checks++;
        if ({inReady, busy, request} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got ready/busy/req %b, expected 000", {inReady, busy, request});
        end
        checks++;
        if (fifoLevel !== 4'd0) begin
            errors++; $display("FAIL reset_level: got %0d, expected 0", fifoLevel);
        end
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        checks++;
        if (inReady !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after_release: got %b, expected 1", inReady);
        end
        $display("reset: done");
    endtask

    task automatic test_single_command;
        int w;
        int n;
        logic f;
        grant = 1'b1;
        push_word(2'd2, 1'b0, 16'hA5A5);
        capture_word(1'b0, 20, w, f);
        checks++;
        if (!f || w !== 1) begin
            errors++; $display("FAIL cmd_start: got found=%b wait=%0d, expected found=1 wait=1", f, w);
        end
        checks++;
        n = word_errors(2'd2, 16'hA5A5);
        if (n !== 0) begin
            errors++; $display("FAIL cmd_waveform: got %0d bad cycles, expected 0", n);
        end
        checks++;
        if ({cap_tx[0], cap_tx[11], cap_tx[12], cap_tx[23], cap_tx[24], cap_tx[28]} !== 6'b110010) begin
            errors++; $display("FAIL cmd_sync_edges: got %b, expected 110010",
                               {cap_tx[0], cap_tx[11], cap_tx[12], cap_tx[23], cap_tx[24], cap_tx[28]});
        end
        checks++;
        if ({cap_tx[PAR0], cap_tx[PAR0+CDIV]} !== 2'b10) begin
            errors++; $display("FAIL cmd_parity: got %b, expected 10", {cap_tx[PAR0], cap_tx[PAR0+CDIV]});
        end
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (busy === 1'b1 && {txA, nTxA, txB, nTxB} === 4'b0000) n++;
            else break;
        end
        checks++;
        if (n !== GAPH * CDIV || busy !== 1'b0) begin
            errors++; $display("FAIL cmd_gap: got %0d gap cycles busy=%b, expected 32 busy=0", n, busy);
        end
        grant = 1'b0;
        $display("single_command: A5A5 on bus A, gap %0d", n);
    endtask

    task automatic test_back_to_back;
        int w;
        int n;
        logic f;
        grant = 1'b1;
        push_word(2'd1, 1'b1, 16'h0001);
        push_word(2'd1, 1'b1, 16'hFFFF);
        capture_word(1'b1, 20, w, f);
        checks++;
        if (!f || w !== 0) begin
            errors++; $display("FAIL b2b_first_start: got found=%b wait=%0d, expected 1/0", f, w);
        end
        checks++;
        n = word_errors(2'd1, 16'h0001);
        if (n !== 0 || cap_tx[PAR0] !== 1'b0) begin
            errors++; $display("FAIL b2b_first_word: got %0d bad, parity %b, expected 0 bad, parity 0", n, cap_tx[PAR0]);
        end
        capture_word(1'b1, 60, w, f);
        checks++;
        if (!f || w !== 1) begin
            errors++; $display("FAIL b2b_contiguous: got found=%b wait=%0d, expected 1/1", f, w);
        end
        checks++;
        n = word_errors(2'd1, 16'hFFFF);
        if (n !== 0 || cap_tx[PAR0] !== 1'b1) begin
            errors++; $display("FAIL b2b_second_word: got %0d bad, parity %b, expected 0 bad, parity 1", n, cap_tx[PAR0]);
        end
        wait_idle(200, n);
        grant = 1'b0;
        $display("back_to_back: 0001 then FFFF on bus B");
    endtask

    task automatic test_fill;
        int w;
        int n;
        logic f;
        grant = 1'b0;
        for (int k = 0; k < DEP; k++) push_word(2'd3, 1'b0, 16'h3C00 | 16'(k));
        checks++;
        if ({inReady, request, busy} !== 3'b010 || fifoLevel !== 4'd8) begin
            errors++; $display("FAIL fill_full: got ready/req/busy %b level %0d, expected 010 level 8",
                               {inReady, request, busy}, fifoLevel);
        end
        push_word(2'd3, 1'b0, 16'hDEAD);
        checks++;
        if (fifoLevel !== 4'd8 || {txA, nTxA, txB, nTxB} !== 4'b0000) begin
            errors++; $display("FAIL fill_ninth_ignored: got level %0d lines %b, expected 8 0000",
                               fifoLevel, {txA, nTxA, txB, nTxB});
        end
        grant = 1'b1;
        for (int k = 0; k < DEP; k++) begin
            capture_word(1'b0, 60, w, f);
            n = word_errors(2'd3, 16'h3C00 | 16'(k));
            checks++;
            if (!f || w !== 1 || n !== 0) begin
                errors++; $display("FAIL fill_word%0d: got found=%b wait=%0d bad=%0d, expected 1/1/0", k, f, w, n);
            end
        end
        wait_idle(200, n);
        checks++;
        if (busy !== 1'b0 || fifoLevel !== 4'd0 || request !== 1'b0) begin
            errors++; $display("FAIL fill_drained: got busy %b level %0d req %b, expected 0 0 0", busy, fifoLevel, request);
        end
        grant = 1'b0;
        $display("fill: 8 words queued and sent");
    endtask

    task automatic test_abort;
        int n;
        grant = 1'b0;
        for (int k = 0; k < 4; k++) push_word(2'd2, 1'b0, 16'h1248 + 16'(k));
        grant = 1'b1;
        n = 0;
        while ((txA | nTxA) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        checks++;
        if (fifoLevel !== 4'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre: got level %0d busy %b, expected 3 1", fifoLevel, busy);
        end
        abort   = 1'b1;
        inValid = 1'b1;
        inType  = 2'd2;
        inBus   = 1'b0;
        inData  = 16'hBEEF;
        @(negedge clk);
        abort   = 1'b0;
        inValid = 1'b0;
        checks++;
        if ({txA, nTxA, txB, nTxB} !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_lines: got lines %b busy %b, expected 0000 0", {txA, nTxA, txB, nTxB}, busy);
        end
        @(negedge clk);
        checks++;
        if (fifoLevel !== 4'd0 || inReady !== 1'b1) begin
            errors++; $display("FAIL abort_flush: got level %0d ready %b, expected 0 1", fifoLevel, inReady);
        end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({txA, nTxA, txB, nTxB, busy} !== 5'b00000) n++;
        end
        checks++;
        if (n !== 0 || request !== 1'b0) begin
            errors++; $display("FAIL abort_quiet: got %0d active cycles req %b, expected 0 0", n, request);
        end
        grant = 1'b0;
        $display("abort: flushed mid-data");
    endtask

    task automatic test_discard;
        int w;
        int n;
        logic f;
        grant = 1'b0;
        push_word(2'd2, 1'b0, 16'h1234);
        push_word(2'd0, 1'b0, 16'hFFFF);
        push_word(2'd2, 1'b0, 16'h0F0F);
        grant = 1'b1;
        capture_word(1'b0, 20, w, f);
        n = word_errors(2'd2, 16'h1234);
        checks++;
        if (!f || w !== 1 || n !== 0) begin
            errors++; $display("FAIL discard_first: got found=%b wait=%0d bad=%0d, expected 1/1/0", f, w, n);
        end
        capture_word(1'b0, 100, w, f);
        checks++;
        if (!f || w !== GAPH * CDIV + 3) begin
            errors++; $display("FAIL discard_gap: got found=%b wait=%0d, expected 1/35", f, w);
        end
        n = word_errors(2'd2, 16'h0F0F);
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL discard_second: got %0d bad cycles, expected 0", n);
        end
        wait_idle(200, n);
        grant = 1'b0;
        $display("discard: type-0 word skipped with gap");
    endtask

    task automatic test_bus_switch;
        int w;
        int n;
        logic f;
        grant = 1'b0;
        push_word(2'd2, 1'b0, 16'hAAAA);
        push_word(2'd3, 1'b1, 16'h5555);
        grant = 1'b1;
        capture_word(1'b0, 20, w, f);
        n = word_errors(2'd2, 16'hAAAA);
        checks++;
        if (!f || w !== 1 || n !== 0) begin
            errors++; $display("FAIL switch_first: got found=%b wait=%0d bad=%0d, expected 1/1/0", f, w, n);
        end
        capture_word(1'b1, 100, w, f);
        n = word_errors(2'd3, 16'h5555);
        checks++;
        if (!f || w !== GAPH * CDIV + 2 || n !== 0) begin
            errors++; $display("FAIL switch_second: got found=%b wait=%0d bad=%0d, expected 1/34/0", f, w, n);
        end
        wait_idle(200, n);
        grant = 1'b0;
        $display("bus_switch: A then B after gap");
    endtask

    task automatic test_async_reset;
        grant = 1'b1;
        push_word(2'd1, 1'b0, 16'h00FF);
        push_word(2'd1, 1'b0, 16'h1111);
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || fifoLevel !== 4'd1) begin
            errors++; $display("FAIL areset_pre: got busy %b level %0d, expected 1 1", busy, fifoLevel);
        end
        #2;
        nRst = 1'b0;
        #1;
        checks++;
        if ({txA, nTxA, txB, nTxB, busy, inReady} !== 6'b000000 || fifoLevel !== 4'd0) begin
            errors++; $display("FAIL areset_immediate: got lines/busy/ready %b level %0d, expected 000000 0",
                               {txA, nTxA, txB, nTxB, busy, inReady}, fifoLevel);
        end
        @(negedge clk);
        grant = 1'b0;
        nRst  = 1'b1;
        @(negedge clk);
        checks++;
        if (inReady !== 1'b1 || fifoLevel !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL areset_release: got ready %b level %0d busy %b, expected 1 0 0",
                               inReady, fifoLevel, busy);
        end
        $display("async_reset: cleared mid-word");
    endtask

    initial begin
        test_reset;
        test_single_command;
        test_back_to_back;
        test_fill;
        test_abort;
        test_discard;
        test_bus_switch;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
